// File: rtl/ring_meas_sequencer_pkg.sv
// Shared types and constants for the ring-oscillator measurement sequencer.
// States, error codes, readout-mux selects and a parameter clamp helper.
package ring_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ENABLE,
        PRECHECK,
        FIRE,
        MEASURE,
        STOP,
        POLL,
        READ,
        EVAL,
        ABORT,
        DONE
    } state_t;

    localparam logic [2:0] ERR_OK        = 3'd0;
    localparam logic [2:0] ERR_NOT_CLEAR = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT   = 3'd2;
    localparam logic [2:0] ERR_SMALL     = 3'd3;
    localparam logic [2:0] ERR_OVF       = 3'd4;
    localparam logic [2:0] ERR_MISMATCH  = 3'd5;

    localparam logic [2:0] SEL_IDLE   = 3'd0;
    localparam logic [2:0] SEL_C0_B0  = 3'd1;
    localparam logic [2:0] SEL_C0_B1  = 3'd2;
    localparam logic [2:0] SEL_C0_B2  = 3'd3;
    localparam logic [2:0] SEL_C1_B0  = 3'd4;
    localparam logic [2:0] SEL_C1_B1  = 3'd5;
    localparam logic [2:0] SEL_C1_B2  = 3'd6;
    localparam logic [2:0] SEL_STATUS = 3'd7;

    localparam int READ_CYCLES = 12;

    // A zero-length phase would never terminate, so it is stretched to one cycle.
    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/ring_meas_sequencer_eval.sv
// Combinational verdict on the two raw ring counts plus tick conversion.
// Checks in priority order: too small, overflow (bit23 clear), mismatch.
module ring_seq_eval
    import ring_seq_pkg::*;
#(
    parameter int MIN_COUNT = 10,
    parameter int MAX_DIFF  = 3
) (
    input  logic [23:0] count0,
    input  logic [23:0] count1,
    output logic [23:0] ticks0,
    output logic [23:0] ticks1,
    output logic [2:0]  err
);

    localparam logic [23:0] MIN_C = 24'(MIN_COUNT);
    localparam logic [24:0] MAX_D = 25'(MAX_DIFF);

    logic [24:0] diff;

    always_comb begin
        ticks0 = 24'hFFFFFF - count0;
        ticks1 = 24'hFFFFFF - count1;
        // Subtract the smaller from the larger so the difference never wraps.
        if (count0 >= count1)
            diff = {1'b0, count0} - {1'b0, count1};
        else
            diff = {1'b0, count1} - {1'b0, count0};
        err = ERR_OK;
        if (count0 < MIN_C || count1 < MIN_C)
            err = ERR_SMALL;
        else if (!count0[23] || !count1[23])
            err = ERR_OVF;
        else if (diff > MAX_D)
            err = ERR_MISMATCH;
    end

endmodule

// File: rtl/ring_meas_sequencer.sv
// Sequencer driving the ring-oscillator speed-test macro and reading both counters.
// Optional status precheck before firing: define RING_SEQ_PRECHECK_EN.
module ring_meas_sequencer
    import ring_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int TRIG_CYCLES   = 2,
    parameter int MEAS_CYCLES   = 3,
    parameter int POLL_TIMEOUT  = 16,
    parameter int MIN_COUNT     = 10,
    parameter int MAX_DIFF      = 3
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic [7:0]  meas_data,
    output logic [1:0]  ring_en,
    output logic [2:0]  sel,
    output logic        trig,
    output logic        busy,
    output logic        done,
    output logic [23:0] count0,
    output logic [23:0] count1,
    output logic [23:0] ticks0,
    output logic [23:0] ticks1,
    output logic [2:0]  err_code
);

    localparam int SET_N = at_least_one(SETTLE_CYCLES);
    localparam int TRG_N = at_least_one(TRIG_CYCLES);
    localparam int MEA_N = at_least_one(MEAS_CYCLES);
    localparam int POL_N = at_least_one(POLL_TIMEOUT);
    localparam int M1 = (SET_N > TRG_N) ? SET_N : TRG_N;
    localparam int M2 = (MEA_N > POL_N) ? MEA_N : POL_N;
    localparam int M3 = (M1 > M2) ? M1 : M2;
    localparam int CNT_MAX = (M3 > READ_CYCLES) ? M3 : READ_CYCLES;
    localparam int CW = $clog2(CNT_MAX);

    localparam logic [CW-1:0] SET_L = CW'(SET_N - 1);
    localparam logic [CW-1:0] TRG_L = CW'(TRG_N - 1);
    localparam logic [CW-1:0] MEA_L = CW'(MEA_N - 1);
    localparam logic [CW-1:0] POL_L = CW'(POL_N - 1);
    localparam logic [CW-1:0] RD_L  = CW'(READ_CYCLES - 1);

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    err_d, ev_err, sel_d;
    logic [1:0]    ring_en_d;
    logic          trig_d, busy_d, done_d;
    logic [23:0]   ev_t0, ev_t1;

    ring_seq_eval #(
        .MIN_COUNT(MIN_COUNT),
        .MAX_DIFF (MAX_DIFF)
    ) u_eval (
        .count0(count0),
        .count1(count1),
        .ticks0(ev_t0),
        .ticks1(ev_t1),
        .err   (ev_err)
    );

    always_comb begin
        state_d = state;
        cnt_d   = cnt + CW'(1);
        err_d   = err_code;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = ENABLE;
                    err_d   = ERR_OK;
                end
            end
            ENABLE: if (cnt == SET_L) begin
                cnt_d = '0;
`ifdef RING_SEQ_PRECHECK_EN
                state_d = PRECHECK;
`else
                state_d = FIRE;
`endif
            end
`ifdef RING_SEQ_PRECHECK_EN
            // First cycle lets the status select settle; second samples fired.
            PRECHECK: if (cnt == CW'(1)) begin
                cnt_d = '0;
                if (meas_data[6]) begin
                    err_d   = ERR_NOT_CLEAR;
                    state_d = ABORT;
                end else begin
                    state_d = FIRE;
                end
            end
`endif
            FIRE: if (cnt == TRG_L) begin
                cnt_d   = '0;
                state_d = MEASURE;
            end
            MEASURE: if (cnt == MEA_L) begin
                cnt_d   = '0;
                state_d = STOP;
            end
            STOP: begin
                cnt_d   = '0;
                state_d = POLL;
            end
            POLL: if (meas_data[6]) begin
                cnt_d   = '0;
                state_d = READ;
            end else if (cnt == POL_L) begin
                cnt_d   = '0;
                err_d   = ERR_TIMEOUT;
                state_d = ABORT;
            end
            READ: if (cnt == RD_L) begin
                cnt_d   = '0;
                state_d = EVAL;
            end
            EVAL: begin
                cnt_d   = '0;
                err_d   = ev_err;
                state_d = DONE;
            end
            ABORT: begin
                cnt_d   = '0;
                state_d = DONE;
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Macro-facing outputs are registered from the next state.
        ring_en_d = 2'b00;
        if (state_d inside {ENABLE, PRECHECK, FIRE, MEASURE})
            ring_en_d = 2'b11;
        trig_d = (state_d == FIRE);
        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
        sel_d  = SEL_IDLE;
        if (state_d inside {PRECHECK, STOP, POLL})
            sel_d = SEL_STATUS;
        else if (state_d == READ)
            sel_d = SEL_C0_B0 + cnt_d[3:1];
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            cnt      <= '0;
            ring_en  <= 2'b00;
            sel      <= SEL_IDLE;
            trig     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_code <= ERR_OK;
            count0   <= '0;
            count1   <= '0;
            ticks0   <= '0;
            ticks1   <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            ring_en  <= ring_en_d;
            sel      <= sel_d;
            trig     <= trig_d;
            busy     <= busy_d;
            done     <= done_d;
            err_code <= err_d;
            if (state == READ && cnt[0]) begin
                case (sel)
                    SEL_C0_B0: count0[7:0]   <= meas_data;
                    SEL_C0_B1: count0[15:8]  <= meas_data;
                    SEL_C0_B2: count0[23:16] <= meas_data;
                    SEL_C1_B0: count1[7:0]   <= meas_data;
                    SEL_C1_B1: count1[15:8]  <= meas_data;
                    SEL_C1_B2: count1[23:16] <= meas_data;
                    default: begin
                    end
                endcase
            end
            if (state == EVAL) begin
                ticks0 <= ev_t0;
                ticks1 <= ev_t1;
            end
        end
    end

endmodule

// File: tb/tb_ring_meas_sequencer.sv
// Randomized bench for ring_meas_sequencer against a behavioural macro model.
// Expected verdicts come from the count rules applied with plain arithmetic.
module tb_ring_meas_sequencer;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic [7:0]  meas_data;
    logic [1:0]  ring_en;
    logic [2:0]  sel;
    logic        trig;
    logic        busy;
    logic        done;
    logic [23:0] count0;
    logic [23:0] count1;
    logic [23:0] ticks0;
    logic [23:0] ticks1;
    logic [2:0]  err_code;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ring_meas_sequencer dut (
        .clk      (clk),
        .nrst     (nrst),
        .start    (start),
        .meas_data(meas_data),
        .ring_en  (ring_en),
        .sel      (sel),
        .trig     (trig),
        .busy     (busy),
        .done     (done),
        .count0   (count0),
        .count1   (count1),
        .ticks0   (ticks0),
        .ticks1   (ticks1),
        .err_code (err_code)
    );

    // Macro model: fixed counts per run; fired mode 0=after delay, 1=never, 2=stuck.
    logic [23:0] m_c0 = '0;
    logic [23:0] m_c1 = '0;
    int          m_mode = 0;
    int          m_delay = 3;
    logic        armed = 1'b0;
    int          fcnt = 0;
    logic [7:0]  junk = 8'h00;
    logic        fired;

    always @(posedge clk) begin
        junk <= 8'($urandom);
        if (!busy) begin
            armed <= 1'b0;
            fcnt  <= 0;
        end else if (trig) begin
            armed <= 1'b1;
            fcnt  <= 0;
        end else if (armed && fcnt < 1000) begin
            fcnt <= fcnt + 1;
        end
    end

    always_comb begin
        fired = (m_mode == 2) || (m_mode == 0 && armed && fcnt >= m_delay);
        case (sel)
            3'd1: meas_data = m_c0[7:0];
            3'd2: meas_data = m_c0[15:8];
            3'd3: meas_data = m_c0[23:16];
            3'd4: meas_data = m_c1[7:0];
            3'd5: meas_data = m_c1[15:8];
            3'd6: meas_data = m_c1[23:16];
            3'd7: meas_data = {junk[7], fired, junk[5:0]};
            default: meas_data = junk;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_err(input logic [23:0] a, input logic [23:0] b);
        int ia, ib, d;
        ia = int'(a);
        ib = int'(b);
        d = (ia > ib) ? ia - ib : ib - ia;
        if (ia < 10 || ib < 10) return 3;
        if (ia < 32'h800000 || ib < 32'h800000) return 4;
        if (d > 3) return 5;
        return 0;
    endfunction

    // Expected register contents carried across runs (aborts keep them).
    logic [23:0] e_c0 = '0, e_c1 = '0, e_t0 = '0, e_t1 = '0;

    task automatic run_seq(input string tag, input logic [23:0] c0,
                           input logic [23:0] c1, input int mode, input int dly);
        int  e_err;
        int  cyc;
        bit  seen;
        bit  stray;
        bit  pre_abort;
        m_c0 = c0;
        m_c1 = c1;
        m_mode = mode;
        m_delay = dly;
`ifdef RING_SEQ_PRECHECK_EN
        pre_abort = (mode == 2);
`else
        pre_abort = 1'b0;
`endif
        if (pre_abort) begin
            e_err = 1;
        end else if (mode == 1) begin
            e_err = 2;
        end else begin
            e_err = ref_err(c0, c1);
            e_c0 = c0;
            e_c1 = c1;
            e_t0 = 24'hFFFFFF - c0;
            e_t1 = 24'hFFFFFF - c1;
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 4);
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_err"}, err_code, e_err);
        chk({tag, "_c0"}, count0, e_c0);
        chk({tag, "_c1"}, count1, e_c1);
        chk({tag, "_t0"}, ticks0, e_t0);
        chk({tag, "_t1"}, ticks1, e_t1);
        chk({tag, "_idle_out"}, {ring_en, sel, trig}, 0);
        // A start coinciding with done must be ignored.
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done || busy) stray = 1'b1;
            @(negedge clk);
        end
        chk({tag, "_no_restart"}, stray, 0);
    endtask

    task automatic reset_mid_measure();
        int  cyc;
        bit  stray;
        m_mode = 0;
        m_delay = 3;
        m_c0 = 24'hFFFFF0;
        m_c1 = 24'hFFFFF1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (!trig && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        while (trig && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_reach_measure", (cyc < 50) ? 1 : 0, 1);
        chk("rst_ring_on", ring_en, 2'b11);
        #2 nrst = 1'b0;
        #1;
        chk("rst_ring_off", ring_en, 0);
        chk("rst_trig_off", trig, 0);
        chk("rst_busy_off", busy, 0);
        e_c0 = '0;
        e_c1 = '0;
        e_t0 = '0;
        e_t1 = '0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy || ring_en != 0) stray = 1'b1;
        end
        chk("rst_stays_idle", stray, 0);
    endtask

    initial begin
        logic [23:0] a, b, t;
        int k, mode;
        nrst = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ring_en", ring_en, 0);
        chk("rst_sel", sel, 0);
        chk("rst_trig", trig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count0", count0, 0);
        chk("rst_count1", count1, 0);
        chk("rst_ticks0", ticks0, 0);
        chk("rst_ticks1", ticks1, 0);
        chk("rst_err", err_code, 0);
        nrst = 1'b1;
        @(negedge clk);

        run_seq("pass", 24'hFFFFF0, 24'hFFFFF0, 0, 3);
        run_seq("mismatch", 24'hFFFFF0, 24'hFFFFE0, 0, 3);
        run_seq("timeout", 24'hFFFFF0, 24'hFFFFF0, 1, 3);
        run_seq("stuck", 24'hFFFFF2, 24'hFFFFF0, 2, 3);
        run_seq("ovf", 24'h7FFFFF, 24'hFFFFF0, 0, 3);
        run_seq("small", 24'h7FFFFF, 24'h000005, 0, 3);
        run_seq("diff3", 24'hFFFF00, 24'hFFFF03, 0, 5);
        run_seq("diff4", 24'hFFFF04, 24'hFFFF00, 0, 2);
        run_seq("min10", 24'h00000A, 24'h800000, 0, 1);
        reset_mid_measure();
        run_seq("post_rst", 24'hFFFFF0, 24'hFFFFF0, 0, 3);

        for (int n = 0; n < 25; n++) begin
            k = int'($urandom % 6);
            case (k)
                0: begin
                    a = 24'hF00000 | 24'($urandom_range(0, 24'h0FFFFF));
                    b = a - 24'($urandom_range(0, 6));
                    if ($urandom % 2 == 1) begin
                        t = a;
                        a = b;
                        b = t;
                    end
                end
                1: begin
                    a = 24'($urandom);
                    b = 24'($urandom);
                end
                2: begin
                    a = 24'($urandom_range(0, 24'h7FFFFF));
                    b = 24'hFFFFF0;
                end
                3: begin
                    a = 24'hFFFFF0;
                    b = 24'($urandom_range(0, 15));
                end
                4: begin
                    a = 24'($urandom_range(8, 12));
                    b = 24'($urandom_range(8, 12));
                end
                default: begin
                    a = 24'h800000 | 24'($urandom);
                    b = a;
                end
            endcase
            k = int'($urandom % 8);
            mode = (k == 0) ? 1 : (k == 1) ? 2 : 0;
            run_seq($sformatf("rnd%0d", n), a, b, mode,
                    int'($urandom_range(1, 8)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ring_meas_sequencer.md
Name: ring_meas_sequencer

Overview:
- Autonomous controller for the ring-oscillator speed-test macro: enables both rings, fires a measurement, stops the rings, then reads back both 24-bit counters byte-by-byte through the 3-bit select mux.
- Publishes the raw counts, the tick counts, and a pass/error verdict.
- Sits between the tile's config/start logic and the speed-test macro's {ring_en, sel, trig} inputs and 8-bit output.

Parameters:
- SETTLE_CYCLES, 1, cycles rings run enabled before the fire trigger.
- TRIG_CYCLES, 2, cycles trig is held high.
- MEAS_CYCLES, 3, cycles waited after trig falls, with rings still on.
- POLL_TIMEOUT, 16, max cycles waited for the fired status bit.
- MIN_COUNT, 10, raw count below this is an error.
- MAX_DIFF, 3, max allowed |count0-count1|.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a sequence when idle
- meas_data  in  8  speed-test output byte (bit7 = debug flag, bit6 = fired when sel=7)
- ring_en  out  2  ring enables to macro
- sel  out  3  readout select to macro
- trig  out  1  measurement fire
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at sequence end
- count0  out  24  raw counter 0 (valid after done)
- count1  out  24  raw counter 1
- ticks0  out  24  24'hFFFFFF - count0
- ticks1  out  24  24'hFFFFFF - count1
- err_code  out  3  0 ok, 1 fired-not-clear, 2 fire timeout, 3 count too small, 4 overflow, 5 mismatch

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on nrst.
- Reset state: all outputs registered and zero. ring_en=00, sel=000, trig=0, busy=0, done=0, counts/ticks=0, err_code=0, state IDLE.
- Reset mid-sequence: ring_en drops to 00 immediately (async). No done pulse is produced.
- IDLE: start=1 -> ENABLE next edge; busy=1, err_code cleared. start while busy is ignored.
- ENABLE: ring_en=11, sel=000, hold SETTLE_CYCLES -> PRECHECK (or FIRE if the optional feature is compiled out).
- PRECHECK: sel=111, wait 1 cycle, sample meas_data[6].
  - 1 -> err_code=1, go to ABORT.
  - 0 -> FIRE.
- FIRE: trig=1 for exactly TRIG_CYCLES, sel=000 -> MEASURE.
- MEASURE: trig=0, rings on, MEAS_CYCLES cycles -> STOP.
- STOP: ring_en=00, sel=111 -> POLL.
- POLL: sample meas_data[6] each cycle.
  - 1 -> READ.
  - POLL_TIMEOUT cycles elapsed without it -> err_code=2, go to ABORT.
- READ: sel steps 1..6. Each byte takes 2 cycles: drive sel, then capture meas_data on the following edge.
  - sel 1/2/3 -> count0[7:0]/[15:8]/[23:16].
  - sel 4/5/6 -> count1 bytes in the same order.
  - Total 12 cycles, then EVAL.
- EVAL (1 cycle): compute ticks. First failing check sets err_code, in priority order:
  1. either count < MIN_COUNT -> 3
  2. either count[23]==0 -> 4
  3. |count0-count1| > MAX_DIFF -> 5
  - Difference uses a 25-bit unsigned subtract with no wrap.
  - Next state DONE.
- ABORT: ring_en=00, sel=000, trig=0 -> DONE. Counts keep their previous values.
- DONE: done=1 for one cycle, busy=0, sel=000 -> IDLE.
  - A start arriving in the same cycle as done is ignored.
- Cycle counters are sized by $clog2 of their max parameter. A parameter value of 0 is treated as 1.
- Nominal pass latency from start to done: 1+SETTLE+2+TRIG+MEAS+1+(POLL hits)+12+1+1 edges.

Optional Feature:
- Macro: RING_SEQ_PRECHECK_EN.
- Defined: the PRECHECK state exists and err_code=1 is reachable.
- Undefined: ENABLE transitions directly to FIRE and err_code=1 never occurs. Pass latency is 2 cycles shorter.

Decomposition:
- Package ring_seq_pkg holds:
  - state enum: IDLE, ENABLE, PRECHECK, FIRE, MEASURE, STOP, POLL, READ, EVAL, ABORT, DONE
  - err_code localparams: ERR_OK, ERR_NOT_CLEAR, ERR_TIMEOUT, ERR_SMALL, ERR_OVF, ERR_MISMATCH
  - sel constants: SEL_IDLE=0, SEL_STATUS=7, SEL_C0_B0..SEL_C1_B2=1..6
- One sub-module, ring_seq_eval: purely combinational count checks plus tick computation, instantiated once.

Test Plan:
- Behavioural macro model: counts down from FFFFFF while enabled and triggered, fired set at trig fall+3. Start -> count0=count1=FFFFF0, ticks=F, err_code=0, done pulse exactly once.
- Model with count0=FFFFF0, count1=FFFFE0 -> err_code=5; ticks0=0x0F, ticks1=0x1F.
- Model never sets fired -> POLL times out after 16 cycles -> err_code=2, ring_en=00, done pulses.
- Fired bit stuck at 1 before trig -> err_code=1 with macro defined. With macro undefined the sequence proceeds and ends err_code=0.
- count0=7FFFFF -> err_code=4. Also count1=000005 together with count0=7FFFFF -> err_code=3 (priority check).
- Assert nrst low during MEASURE -> ring_en=00 and trig=0 within the same cycle. After release, state is IDLE, busy=0, no done pulse. A start pulse while busy is ignored.
